// File: rtl/scariv_bru_pkg.sv
// Purpose : shared types, widths and mask helpers for the BRU execution pipe.
// Latency : n/a (types and pure functions only).
// Backpr. : n/a.
package scariv_bru_pkg;

    localparam int XLEN      = 64;
    localparam int VADDR_W   = 39;
    localparam int CMT_ID_W  = 6;
    localparam int GRP_ID_W  = 4;
    localparam int BRTAG_NUM = 8;
    localparam int BRTAG_W   = $clog2(BRTAG_NUM);
    localparam int RNID_W    = 7;

    typedef enum logic [3:0] {
        BEQ  = 4'd0,
        BNE  = 4'd1,
        BLT  = 4'd2,
        BGE  = 4'd3,
        BLTU = 4'd4,
        BGEU = 4'd5,
        JAL  = 4'd6,
        JALR = 4'd7
    } brop_t;

    typedef logic [BRTAG_NUM-1:0] brmask_t;

    // EX0 contents: everything needed to resolve the branch.
    typedef struct packed {
        logic                valid;
        brop_t               op;
        logic [VADDR_W-1:0]  pc;
        logic [XLEN-1:0]     imm;
        logic                rvc;
        logic [XLEN-1:0]     rs1;
        logic [XLEN-1:0]     rs2;
        logic                pred_taken;
        logic [VADDR_W-1:0]  pred_tgt;
        logic [CMT_ID_W-1:0] cmt_id;
        logic [GRP_ID_W-1:0] grp_id;
        logic [BRTAG_W-1:0]  brtag;
        brmask_t             brmask;
        logic                rd_valid;
        logic [RNID_W-1:0]   rd_rnid;
    } bru_ex_t;

    // EX1/EX2 contents: resolved result, operands no longer carried.
    typedef struct packed {
        logic                valid;
        brop_t               op;
        logic [CMT_ID_W-1:0] cmt_id;
        logic [GRP_ID_W-1:0] grp_id;
        logic [BRTAG_W-1:0]  brtag;
        brmask_t             brmask;
        logic                rd_valid;
        logic [RNID_W-1:0]   rd_rnid;
        logic                taken;
        logic                mispred;
        logic [VADDR_W-1:0]  upd_tgt;
        logic [XLEN-1:0]     link;
    } bru_rpt_t;

    // Kill is judged on the mask before any same-cycle clear is applied.
    function automatic logic is_killed(brmask_t m, logic flush, logic kill_v, logic [BRTAG_W-1:0] kill_tag);
        return flush | (kill_v & m[kill_tag]);
    endfunction

    function automatic brmask_t brmask_clr(brmask_t m, logic clr_v, logic [BRTAG_W-1:0] clr_tag);
        brmask_t r;
        r = m;
        if (clr_v) r[clr_tag] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/scariv_bru_exec_pipe_if.sv
// Purpose : issue, control and report bundle of the BRU execution pipe.
// Latency : n/a (wires only). master = issue/commit side, slave = pipe.
// Backpr. : o_iss_stall mirrors i_done_stall back to the issue side.
interface scariv_bru_exec_pipe_if;
    import scariv_bru_pkg::*;

    logic                i_iss_valid;
    brop_t               i_iss_op;
    logic [VADDR_W-1:0]  i_iss_pc;
    logic [XLEN-1:0]     i_iss_imm;
    logic                i_iss_rvc;
    logic [XLEN-1:0]     i_iss_rs1;
    logic [XLEN-1:0]     i_iss_rs2;
    logic                i_iss_pred_taken;
    logic [VADDR_W-1:0]  i_iss_pred_tgt;
    logic [CMT_ID_W-1:0] i_iss_cmt_id;
    logic [GRP_ID_W-1:0] i_iss_grp_id;
    logic [BRTAG_W-1:0]  i_iss_brtag;
    brmask_t             i_iss_brmask;
    logic                i_iss_rd_valid;
    logic [RNID_W-1:0]   i_iss_rd_rnid;
    logic                o_iss_stall;

    logic                i_done_stall;
    logic                i_flush;
    logic                i_brkill_valid;
    logic [BRTAG_W-1:0]  i_brkill_tag;
    logic                i_brclr_valid;
    logic [BRTAG_W-1:0]  i_brclr_tag;

    logic                o_done_valid;
    logic [CMT_ID_W-1:0] o_done_cmt_id;
    logic [GRP_ID_W-1:0] o_done_grp_id;
    logic                o_brupd_valid;
    logic                o_brupd_mispred;
    logic                o_brupd_taken;
    logic [VADDR_W-1:0]  o_brupd_tgt;
    logic [BRTAG_W-1:0]  o_brupd_brtag;
    logic                o_wb_valid;
    logic [RNID_W-1:0]   o_wb_rnid;
    logic [XLEN-1:0]     o_wb_data;
    logic [31:0]         o_perf_br_cnt;
    logic [31:0]         o_perf_mispred_cnt;

    modport master (
        output i_iss_valid, i_iss_op, i_iss_pc, i_iss_imm, i_iss_rvc, i_iss_rs1, i_iss_rs2,
               i_iss_pred_taken, i_iss_pred_tgt, i_iss_cmt_id, i_iss_grp_id, i_iss_brtag,
               i_iss_brmask, i_iss_rd_valid, i_iss_rd_rnid,
               i_done_stall, i_flush, i_brkill_valid, i_brkill_tag, i_brclr_valid, i_brclr_tag,
        input  o_iss_stall, o_done_valid, o_done_cmt_id, o_done_grp_id,
               o_brupd_valid, o_brupd_mispred, o_brupd_taken, o_brupd_tgt, o_brupd_brtag,
               o_wb_valid, o_wb_rnid, o_wb_data, o_perf_br_cnt, o_perf_mispred_cnt
    );

    modport slave (
        input  i_iss_valid, i_iss_op, i_iss_pc, i_iss_imm, i_iss_rvc, i_iss_rs1, i_iss_rs2,
               i_iss_pred_taken, i_iss_pred_tgt, i_iss_cmt_id, i_iss_grp_id, i_iss_brtag,
               i_iss_brmask, i_iss_rd_valid, i_iss_rd_rnid,
               i_done_stall, i_flush, i_brkill_valid, i_brkill_tag, i_brclr_valid, i_brclr_tag,
        output o_iss_stall, o_done_valid, o_done_cmt_id, o_done_grp_id,
               o_brupd_valid, o_brupd_mispred, o_brupd_taken, o_brupd_tgt, o_brupd_brtag,
               o_wb_valid, o_wb_rnid, o_wb_data, o_perf_br_cnt, o_perf_mispred_cnt
    );

endinterface

// File: rtl/scariv_bru_resolve.sv
// Purpose : combinational branch resolve (direction, target, link, mispredict).
// Latency : 0 cycles, sits between EX0 and EX1 registers.
// Backpr. : none; ports: i_ex = EX0 stage contents, o_rpt = resolved record for EX1.
module scariv_bru_resolve
    import scariv_bru_pkg::*;
(
    input  bru_ex_t  i_ex,
    output bru_rpt_t o_rpt
);

    logic               taken;
    logic [VADDR_W-1:0] fallthru;
    logic [VADDR_W-1:0] tgt;

    always_comb begin
        taken = 1'b0;
        case (i_ex.op)
            BEQ:       taken = (i_ex.rs1 == i_ex.rs2);
            BNE:       taken = (i_ex.rs1 != i_ex.rs2);
            BLT:       taken = ($signed(i_ex.rs1) <  $signed(i_ex.rs2));
            BGE:       taken = ($signed(i_ex.rs1) >= $signed(i_ex.rs2));
            BLTU:      taken = (i_ex.rs1 <  i_ex.rs2);
            BGEU:      taken = (i_ex.rs1 >= i_ex.rs2);
            JAL, JALR: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

    // All address arithmetic is modulo 2^VADDR_W; the casts do the truncation.
    assign fallthru = i_ex.pc + (i_ex.rvc ? VADDR_W'(2) : VADDR_W'(4));

    always_comb begin
        tgt = i_ex.pc + VADDR_W'(i_ex.imm);
        if (i_ex.op == JALR) tgt = VADDR_W'(i_ex.rs1 + i_ex.imm) & ~VADDR_W'(1);
    end

    always_comb begin
        o_rpt          = '0;
        o_rpt.valid    = i_ex.valid;
        o_rpt.op       = i_ex.op;
        o_rpt.cmt_id   = i_ex.cmt_id;
        o_rpt.grp_id   = i_ex.grp_id;
        o_rpt.brtag    = i_ex.brtag;
        o_rpt.brmask   = i_ex.brmask;
        o_rpt.rd_valid = i_ex.rd_valid;
        o_rpt.rd_rnid  = i_ex.rd_rnid;
        o_rpt.taken    = taken;
        o_rpt.mispred  = (taken != i_ex.pred_taken) | (taken & (tgt != i_ex.pred_tgt));
        o_rpt.upd_tgt  = taken ? tgt : fallthru;
        o_rpt.link     = XLEN'(fallthru);
    end

endmodule

// File: rtl/scariv_bru_exec_pipe.sv
// Purpose : 3-stage BRU execute (EX0 capture, EX1 resolve, EX2 report) with flush/kill/tag-clear.
// Latency : issue in T -> registered done/brupd/wb outputs in T+3; one op per cycle.
// Backpr. : i_done_stall freezes all stages and is echoed to issue as o_iss_stall.
// Ports   : i_clk, i_reset (async, active high), bus (scariv_bru_exec_pipe_if.slave).
// Option  : SCARIV_BRU_PERF_EN builds 32-bit saturating brupd/mispredict counters, else tied to 0.
module scariv_bru_exec_pipe
    import scariv_bru_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_reset,
    scariv_bru_exec_pipe_if.slave  bus
);

    logic     stall;
    bru_ex_t  iss_ex;
    bru_ex_t  ex0_q, ex0_d;
    bru_rpt_t res_rpt;
    bru_rpt_t ex1_q, ex1_d;
    bru_rpt_t ex2_q, ex2_d;

    assign stall           = bus.i_done_stall;
    assign bus.o_iss_stall = stall;

    always_comb begin
        iss_ex            = '0;
        iss_ex.valid      = bus.i_iss_valid;
        iss_ex.op         = bus.i_iss_op;
        iss_ex.pc         = bus.i_iss_pc;
        iss_ex.imm        = bus.i_iss_imm;
        iss_ex.rvc        = bus.i_iss_rvc;
        iss_ex.rs1        = bus.i_iss_rs1;
        iss_ex.rs2        = bus.i_iss_rs2;
        iss_ex.pred_taken = bus.i_iss_pred_taken;
        iss_ex.pred_tgt   = bus.i_iss_pred_tgt;
        iss_ex.cmt_id     = bus.i_iss_cmt_id;
        iss_ex.grp_id     = bus.i_iss_grp_id;
        iss_ex.brtag      = bus.i_iss_brtag;
        iss_ex.brmask     = bus.i_iss_brmask;
        iss_ex.rd_valid   = bus.i_iss_rd_valid;
        iss_ex.rd_rnid    = bus.i_iss_rd_rnid;
    end

    scariv_bru_resolve u_resolve (
        .i_ex  (ex0_q),
        .o_rpt (res_rpt)
    );

    // Each stage either holds (stall) or takes its upstream; kill is then
    // applied on the pre-clear mask, so same-tag kill+clear still kills.
    always_comb begin
        ex0_d        = stall ? ex0_q : iss_ex;
        ex0_d.valid  = ex0_d.valid & ~is_killed(ex0_d.brmask, bus.i_flush, bus.i_brkill_valid, bus.i_brkill_tag);
        ex0_d.brmask = brmask_clr(ex0_d.brmask, bus.i_brclr_valid, bus.i_brclr_tag);
    end

    always_comb begin
        ex1_d        = stall ? ex1_q : res_rpt;
        ex1_d.valid  = ex1_d.valid & ~is_killed(ex1_d.brmask, bus.i_flush, bus.i_brkill_valid, bus.i_brkill_tag);
        ex1_d.brmask = brmask_clr(ex1_d.brmask, bus.i_brclr_valid, bus.i_brclr_tag);
    end

    always_comb begin
        ex2_d        = stall ? ex2_q : ex1_q;
        ex2_d.valid  = ex2_d.valid & ~is_killed(ex2_d.brmask, bus.i_flush, bus.i_brkill_valid, bus.i_brkill_tag);
        ex2_d.brmask = brmask_clr(ex2_d.brmask, bus.i_brclr_valid, bus.i_brclr_tag);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ex0_q <= '0;
            ex1_q <= '0;
            ex2_q <= '0;
        end else begin
            ex0_q <= ex0_d;
            ex1_q <= ex1_d;
            ex2_q <= ex2_d;
        end
    end

    // Outputs come straight from the EX2 register; JAL needs no frontend update.
    assign bus.o_done_valid    = ex2_q.valid;
    assign bus.o_done_cmt_id   = ex2_q.cmt_id;
    assign bus.o_done_grp_id   = ex2_q.grp_id;
    assign bus.o_brupd_valid   = ex2_q.valid & (ex2_q.op != JAL);
    assign bus.o_brupd_mispred = ex2_q.mispred;
    assign bus.o_brupd_taken   = ex2_q.taken;
    assign bus.o_brupd_tgt     = ex2_q.upd_tgt;
    assign bus.o_brupd_brtag   = ex2_q.brtag;
    assign bus.o_wb_valid      = ex2_q.valid & ex2_q.rd_valid & ((ex2_q.op == JAL) | (ex2_q.op == JALR));
    assign bus.o_wb_rnid       = ex2_q.rd_rnid;
    assign bus.o_wb_data       = ex2_q.link;

`ifdef SCARIV_BRU_PERF_EN
    logic [31:0] perf_br_q;
    logic [31:0] perf_mis_q;
    logic        ld_brupd;

    // Counted on the EX2 load so a stalled op is counted only once.
    assign ld_brupd = ~stall & ex2_d.valid & (ex2_d.op != JAL);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            perf_br_q  <= '0;
            perf_mis_q <= '0;
        end else begin
            if (ld_brupd && (perf_br_q != '1)) perf_br_q <= perf_br_q + 32'd1;
            if (ld_brupd && ex2_d.mispred && (perf_mis_q != '1)) perf_mis_q <= perf_mis_q + 32'd1;
        end
    end

    assign bus.o_perf_br_cnt      = perf_br_q;
    assign bus.o_perf_mispred_cnt = perf_mis_q;
`else
    assign bus.o_perf_br_cnt      = '0;
    assign bus.o_perf_mispred_cnt = '0;
`endif

    iss_while_stall : assert property (@(posedge i_clk) disable iff (i_reset)
        !(bus.i_iss_valid && bus.o_iss_stall));

endmodule
